// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - data-memory port initiator sequencing single/burst loads and stores
// One beat per cycle on the memory bus; read data returns in order two cycles after issue.
module dmem_access_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              busy,
  output logic [1:0]        mem_control,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] CTL_IDLE  = 2'b00;
  localparam logic [1:0] CTL_READ  = 2'b10;
  localparam logic [1:0] CTL_WRITE = 2'b11;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [LEN_W-1:0]  LEN_ONE  = 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [LEN_W-1:0]  remain_q, remain_n;
  logic              last_q, last_n;
  logic [1:0]        mem_control_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic              done_n;
  logic              rd_pend;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      last_q      <= 1'b0;
      mem_control <= CTL_IDLE;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      addr_q      <= addr_n;
      remain_q    <= remain_n;
      last_q      <= last_n;
      mem_control <= mem_control_n;
      mem_addr    <= mem_addr_n;
      mem_wdata   <= mem_wdata_n;
      done        <= done_n;
    end
  end

  // addr_q always holds the next address to put on the bus; remain_q counts beats after the current one
  always_comb begin
    state_n       = state;
    addr_n        = addr_q;
    remain_n      = remain_q;
    last_n        = last_q;
    mem_control_n = CTL_IDLE;
    mem_addr_n    = mem_addr;
    mem_wdata_n   = mem_wdata;
    done_n        = 1'b0;
    req_ready     = (state == S_IDLE) && !reset;
    wr_ready      = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          remain_n = req_len;
          last_n   = 1'b0;
          if (req_write) begin
            state_n = S_WRITE;
            addr_n  = req_addr;
          end else begin
            state_n       = S_READ;
            mem_control_n = CTL_READ;
            mem_addr_n    = req_addr;
            addr_n        = req_addr + ADDR_ONE;
          end
        end
      end
      S_READ: begin
        if (remain_q == '0) begin
          state_n = S_DRAIN;
        end else begin
          mem_control_n = CTL_READ;
          mem_addr_n    = addr_q;
          addr_n        = addr_q + ADDR_ONE;
          remain_n      = remain_q - LEN_ONE;
        end
      end
      S_DRAIN: begin
        // only the final beat is still in flight; finish together with its return
        if (rd_pend) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      S_WRITE: begin
        if (last_q) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          wr_ready = 1'b1;
          if (wr_valid) begin
            mem_control_n = CTL_WRITE;
            mem_addr_n    = addr_q;
            mem_wdata_n   = wr_data;
            addr_n        = addr_q + ADDR_ONE;
            if (remain_q == '0) begin
              last_n = 1'b1;
            end else begin
              remain_n = remain_q - LEN_ONE;
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // stage 1: beat was on the bus last cycle, so mem_rdata is valid now
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pend  <= (mem_control == CTL_READ);
      rd_valid <= rd_pend;
      if (rd_pend) begin
        rd_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - scoreboard bench for dmem_access_unit against a 1-cycle registered memory
module tb_dmem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        done;
  logic        busy;
  logic [1:0]  mem_control;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  always #5 clock = ~clock;

  dmem_access_unit #(.ADDR_W(16), .DATA_W(16), .LEN_W(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .busy(busy),
    .mem_control(mem_control), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [15:0] ram     [0:65535];
  logic [15:0] exp_ram [0:65535];

  always @(posedge clock) begin
    if (mem_control == 2'b10) mem_rdata <= ram[mem_addr];
    else if (mem_control == 2'b11) ram[mem_addr] <= mem_wdata;
  end

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [33:0] beat_q [$];
  logic [15:0] rd_q [$];
  logic [1:0]  ctl_hist  [0:255];
  logic [15:0] addr_hist [0:255];
  int          last_rd_cyc = -1;
  logic [15:0] last_rd_data = '0;
  int          done_count = 0;
  logic [15:0] wdat [0:15];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [33:0] mon_b;
  always @(negedge clock) begin
    ctl_hist[cyc % 256]  = mem_control;
    addr_hist[cyc % 256] = mem_addr;
    check_eq("ctl_not_01", 32'(mem_control == 2'b01), 0);
    if (mem_control != 2'b00) begin
      check_eq("beat_avail", 32'(beat_q.size() != 0), 1);
      if (beat_q.size() != 0) begin
        mon_b = beat_q.pop_front();
        check_eq("beat_ctl", 32'(mem_control), 32'(mon_b[33:32]));
        check_eq("beat_addr", 32'(mem_addr), 32'(mon_b[31:16]));
        if (mon_b[33:32] == 2'b11) check_eq("beat_wdata", 32'(mem_wdata), 32'(mon_b[15:0]));
      end
    end
    if (rd_valid) begin
      check_eq("rd_avail", 32'(rd_q.size() != 0), 1);
      if (rd_q.size() != 0) check_eq("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
      last_rd_cyc  = cyc;
      last_rd_data = rd_data;
    end
    if (done) done_count++;
  end

  task automatic push_exp(input logic wr, input logic [15:0] a, input int l);
    for (int i = 0; i <= l; i++) begin
      logic [15:0] ai;
      ai = a + 16'(i);
      if (wr) begin
        beat_q.push_back({2'b11, ai, wdat[i]});
        exp_ram[ai] = wdat[i];
      end else begin
        beat_q.push_back({2'b10, ai, 16'h0000});
        rd_q.push_back(exp_ram[ai]);
      end
    end
  endtask

  task automatic accept(input logic wr, input logic [15:0] a, input int l, input logic hold, output int acc);
    logic got;
    got = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = 4'(l);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (req_ready) begin got = 1'b1; break; end
    end
    acc = cyc;
    check_eq("req_accept", 32'(got), 1);
    @(posedge clock); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic feed_writes(input int l, input logic [15:0] mask);
    int idx;
    logic ok;
    idx = 0;
    for (int c = 0; c < 32 && idx <= l; c++) begin
      wr_data  = wdat[idx];
      wr_valid = !((c < 16) && mask[c]);
      @(negedge clock);
      ok = wr_valid && wr_ready;
      @(posedge clock); #1;
      if (ok) idx++;
    end
    wr_valid = 1'b0;
    check_eq("wr_all_sent", idx, l + 1);
    @(negedge clock);
    check_eq("wr_ready_off", 32'(wr_ready), 0);
  endtask

  task automatic wait_done(output int dc);
    logic got;
    got = 1'b0;
    dc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) begin got = 1'b1; dc = cyc; break; end
    end
    check_eq("done_seen", 32'(got), 1);
  endtask

  task automatic do_req(input logic wr, input logic [15:0] a, input int l, input logic [15:0] mask,
                        output int acc, output int dc);
    push_exp(wr, a, l);
    accept(wr, a, l, 1'b0, acc);
    if (wr) feed_writes(l, mask);
    wait_done(dc);
    @(negedge clock);
    check_eq("beats_left", beat_q.size(), 0);
    check_eq("rd_left", rd_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, dc, dc2, d0, l;
    logic seen, wr;
    logic [15:0] a;
    int init_v [17] = '{3, 2, 2, 1, 7, 11, 17, 1, 2, 3, 4, 1, 2, 3, 4, 5, 6};
    for (int i = 0; i < 65536; i++) begin ram[i] = '0; exp_ram[i] = '0; end
    for (int i = 0; i < 17; i++) begin ram[i] = 16'(init_v[i]); exp_ram[i] = 16'(init_v[i]); end
    for (int i = 0; i < 16; i++) wdat[i] = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_ctl", 32'(mem_control), 0);
    check_eq("rst_addr", 32'(mem_addr), 0);
    check_eq("rst_wdata", 32'(mem_wdata), 0);
    check_eq("rst_rd", {15'b0, rd_valid, rd_data}, 0);
    check_eq("rst_flags", {29'b0, done, busy, wr_ready}, 0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check_eq("idle_req_ready", 32'(req_ready), 1);
    check_eq("idle_busy", 32'(busy), 0);

    do_req(1'b0, 16'd4, 0, 16'h0, acc, dc);
    check_eq("t1_ctl", 32'(ctl_hist[(acc + 1) % 256]), 2);
    check_eq("t1_addr", 32'(addr_hist[(acc + 1) % 256]), 4);
    check_eq("t1_latency", dc - acc, 3);
    check_eq("t1_rd_with_done", last_rd_cyc, dc);
    check_eq("t1_rd_data", 32'(last_rd_data), 7);

    do_req(1'b0, 16'd4, 3, 16'h0, acc, dc);
    for (int i = 0; i < 4; i++) check_eq("t2_addr_seq", 32'(addr_hist[(acc + 1 + i) % 256]), 4 + i);
    check_eq("t2_latency", dc - acc, 6);
    check_eq("t2_rd_with_done", last_rd_cyc, dc);
    check_eq("t2_last_data", 32'(last_rd_data), 1);

    wdat[0] = 16'hAAAA; wdat[1] = 16'hBBBB;
    do_req(1'b1, 16'd20, 1, 16'b10, acc, dc);
    check_eq("t3_bus0", 32'(ctl_hist[(acc + 2) % 256]), 3);
    check_eq("t3_bubble", 32'(ctl_hist[(acc + 3) % 256]), 0);
    check_eq("t3_bus1", 32'(ctl_hist[(acc + 4) % 256]), 3);
    check_eq("t3_done_cyc", dc - acc, 5);
    do_req(1'b0, 16'd20, 1, 16'h0, acc, dc);
    check_eq("t3_readback", 32'(last_rd_data), 32'h0000BBBB);

    wdat[0] = 16'h1234; wdat[1] = 16'h5678;
    d0 = done_count;
    do_req(1'b1, 16'hFFFF, 1, 16'h0, acc, dc);
    check_eq("t4_addr_ffff", 32'(addr_hist[(acc + 2) % 256]), 32'hFFFF);
    check_eq("t4_addr_wrap", 32'(addr_hist[(acc + 3) % 256]), 0);
    repeat (4) @(negedge clock);
    check_eq("t4_done_once", done_count - d0, 1);
    do_req(1'b0, 16'hFFFF, 1, 16'h0, acc, dc);

    push_exp(1'b0, 16'd0, 3);
    push_exp(1'b0, 16'd16, 0);
    accept(1'b0, 16'd0, 3, 1'b1, acc);
    req_addr = 16'd16; req_len = 4'd0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        check_eq("t5_ready_at_done", 32'(req_ready), 1);
        check_eq("t5_idle_at_done", 32'(busy), 0);
        check_eq("t5_done_cyc", cyc - acc, 6);
        break;
      end
      check_eq("t5_busy", 32'(busy), 1);
      check_eq("t5_no_ready", 32'(req_ready), 0);
    end
    check_eq("t5_done_seen", 32'(seen), 1);
    @(posedge clock); #1 req_valid = 1'b0;
    @(negedge clock);
    check_eq("t5_second_ctl", 32'(mem_control), 2);
    check_eq("t5_second_addr", 32'(mem_addr), 16);
    wait_done(dc2);
    @(negedge clock);
    check_eq("t5_second_data", 32'(last_rd_data), 6);
    check_eq("t5_beats_left", beat_q.size(), 0);
    check_eq("t5_rd_left", rd_q.size(), 0);

    push_exp(1'b0, 16'd8, 7);
    accept(1'b0, 16'd8, 7, 1'b0, acc);
    @(negedge clock);
    @(negedge clock);
    check_eq("t6_second_beat", 32'(mem_addr), 9);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_async_ctl", 32'(mem_control), 0);
    check_eq("t6_async_busy", 32'(busy), 0);
    beat_q.delete();
    rd_q.delete();
    repeat (2) begin
      @(negedge clock);
      check_eq("t6_no_rd_rst", 32'(rd_valid), 0);
      check_eq("t6_no_done_rst", 32'(done), 0);
    end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check_eq("t6_ready_after", 32'(req_ready), 1);
    repeat (6) begin
      @(negedge clock);
      check_eq("t6_no_rd", 32'(rd_valid), 0);
      check_eq("t6_no_done", 32'(done), 0);
    end
    do_req(1'b0, 16'd9, 0, 16'h0, acc, dc);
    check_eq("t6_recover", 32'(last_rd_data), 3);

    for (int n = 0; n < 6; n++) begin
      wr = 1'(n % 2 == 0);
      a  = 16'($urandom);
      l  = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) wdat[i] = 16'($urandom);
      do_req(wr, a, l, 16'h0, acc, dc);
      check_eq("rnd_latency", dc - acc, l + 3);
      if (wr) do_req(1'b0, a, l, 16'h0, acc, dc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
